// File: rtl/adc_tx_pkg.sv
// Shared definitions for the ADC-to-UART frame path.
//   HEADER_DEFAULT   : first byte of every frame
//   FRAME_LEN_*      : frame length without / with the XOR checksum byte
//   state_t          : frame packer FSM encoding
//   last_index()     : byte index of the final frame byte for a given checksum setting
package adc_tx_pkg;

    localparam logic [7:0] HEADER_DEFAULT  = 8'hA5;
    localparam int         FRAME_LEN_NOCHK = 5;
    localparam int         FRAME_LEN_CHK   = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    function automatic logic [2:0] last_index(input bit chk_en);
        return chk_en ? 3'(FRAME_LEN_CHK - 1) : 3'(FRAME_LEN_NOCHK - 1);
    endfunction

endpackage

// File: rtl/frame_byte_sel.sv
// Combinational frame byte selector.
//   idx  : byte index within the frame (0 = header)
//   ch0  : latched channel 0 sample
//   ch1  : latched channel 1 sample
//   data : frame byte for idx (checksum at index 5, zero beyond)
module frame_byte_sel
    import adc_tx_pkg::*;
#(
    parameter logic [7:0] Header = HEADER_DEFAULT
) (
    input  logic [2:0]  idx,
    input  logic [11:0] ch0,
    input  logic [11:0] ch1,
    output logic [7:0]  data
);

    // Header is deliberately left out of the checksum.
    logic [7:0] chk;
    assign chk = {4'b0, ch0[11:8]} ^ ch0[7:0] ^ {4'b0, ch1[11:8]} ^ ch1[7:0];

    always_comb begin
        data = 8'h00;
        case (idx)
            3'd0:    data = Header;
            3'd1:    data = {4'b0, ch0[11:8]};
            3'd2:    data = ch0[7:0];
            3'd3:    data = {4'b0, ch1[11:8]};
            3'd4:    data = ch1[7:0];
            3'd5:    data = chk;
            default: data = 8'h00;
        endcase
    end

endmodule

// File: rtl/adc_frame_packer.sv
// Packs the two latched 12-bit ADC channel results into a byte frame and
// feeds it to the byte transmitter with a start / end-of-transmission handshake.
//   clk_i      : system clock
//   rst_i      : synchronous active-high reset
//   eos_i      : sample-valid strobe for doutch0_i / doutch1_i
//   doutch0_i  : channel 0 sample
//   doutch1_i  : channel 1 sample
//   eot_i      : transmitter finished the current byte
//   st_o       : one-cycle start strobe to transmitter
//   data_o     : byte to transmit, held until the next st_o
//   busy_o     : frame in flight
//   eof_o      : one-cycle strobe after the last byte completes
//   ovf_o      : sticky, a sample arrived while busy
//
// state | meaning
// IDLE  | waiting for eos_i; data_o keeps the last byte sent
// START | st_o is high this cycle, data_o holds byte[idx]
// WAIT  | waiting for eot_i on byte[idx]
module adc_frame_packer
    import adc_tx_pkg::*;
#(
    parameter logic [7:0] Header = HEADER_DEFAULT,
    parameter bit         ChkEn  = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        eos_i,
    input  logic [11:0] doutch0_i,
    input  logic [11:0] doutch1_i,
    input  logic        eot_i,
    output logic        st_o,
    output logic [7:0]  data_o,
    output logic        busy_o,
    output logic        eof_o,
    output logic        ovf_o
);

    localparam logic [2:0] LAST_IDX = last_index(ChkEn);

    state_t      state;
    logic [2:0]  idx;
    logic [11:0] ch0_q;
    logic [11:0] ch1_q;
    logic [2:0]  sel_idx;
    logic [7:0]  sel_data;

    // Look up the byte that will be launched on the next st_o: the header when
    // leaving IDLE, otherwise the byte after the one currently in flight.
    assign sel_idx = (state == ST_WAIT) ? idx + 3'd1 : 3'd0;

    frame_byte_sel #(
        .Header (Header)
    ) u_byte_sel (
        .idx  (sel_idx),
        .ch0  (ch0_q),
        .ch1  (ch1_q),
        .data (sel_data)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= ST_IDLE;
            idx    <= 3'd0;
            ch0_q  <= 12'h000;
            ch1_q  <= 12'h000;
            st_o   <= 1'b0;
            data_o <= 8'h00;
            eof_o  <= 1'b0;
            ovf_o  <= 1'b0;
        end else begin
            st_o  <= 1'b0;
            eof_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (eos_i) begin
                        ch0_q  <= doutch0_i;
                        ch1_q  <= doutch1_i;
                        idx    <= 3'd0;
                        st_o   <= 1'b1;
                        data_o <= sel_data;
                        state  <= ST_START;
                    end
                end
                ST_START: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (eot_i) begin
                        if (idx == LAST_IDX) begin
                            eof_o <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            idx    <= idx + 3'd1;
                            st_o   <= 1'b1;
                            data_o <= sel_data;
                            state  <= ST_START;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
            // A sample arriving mid-frame is dropped; only the flag records it.
            if (eos_i && (state != ST_IDLE))
                ovf_o <= 1'b1;
        end
    end

    assign busy_o = (state != ST_IDLE);

endmodule
